cpu_core: RTL and testbench

Parametrised multi-cycle accumulator-style CPU core: the next generation of the 4-register fetch/execute block. It has a configurable datapath width, register count and program depth. It holds its own program memory, which an external loader fills while the core is idle. The core runs a fixed fetch/execute state machine with ALU flags, conditional jumps, HALT, and a stalling output port with a valid/ready handshake.

---
 rtl/cpu_core.sv | 192 +++++++++++++++++++
 tb/tb_cpu_core.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle accumulator-style CPU with its own program memory,
// a fetch/execute state machine, Z/C flags and a valid/ready output port.
//
// state | meaning
// IDLE  | stopped; program loads accepted; start begins at pc=0
// FETCH | instruction register <= mem[pc]
// EXEC  | execute, write back, update pc; OUT stalls here until out_ready
module cpu_core #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 4,
    localparam int REG_W   = $clog2(NUM_REGS),
    localparam int INSTR_W = 4 + 2 * REG_W + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [REG_W-1:0]   dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [ADDR_W-1:0]  pc,
    output logic               running,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state, state_next;
    logic [INSTR_W-1:0]  mem [2**ADDR_W];
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                flag_z, flag_c;
    logic [DATA_W-1:0]   out_hold;

    logic [3:0]          opcode;
    logic [REG_W-1:0]    rd_idx, rs_idx;
    logic [DATA_W-1:0]   imm, rd_val, rs_val;
    logic [ADDR_W-1:0]   jump_target;
    logic [DATA_W:0]     sum_rs, sum_imm, diff;

    logic [ADDR_W-1:0]   pc_next;
    logic                wr_en, flag_en, out_fire, halt_set;
    logic [DATA_W-1:0]   wr_val;
    logic                alu_z, alu_c;

    assign opcode      = ir[INSTR_W-1 -: 4];
    assign rd_idx      = ir[INSTR_W-5 -: REG_W];
    assign rs_idx      = ir[DATA_W +: REG_W];
    assign imm         = ir[DATA_W-1:0];
    assign rd_val      = regs[rd_idx];
    assign rs_val      = regs[rs_idx];
    assign jump_target = imm[ADDR_W-1:0];

    // The extra top bit of each result is carry out, or borrow for diff.
    assign sum_rs  = {1'b0, rd_val} + {1'b0, rs_val};
    assign sum_imm = {1'b0, rd_val} + {1'b0, imm};
    assign diff    = {1'b0, rd_val} - {1'b0, rs_val};

    always_comb begin
        state_next = state;
        pc_next    = pc;
        wr_en      = 1'b0;
        wr_val     = rd_val;
        flag_en    = 1'b0;
        alu_c      = flag_c;
        out_fire   = 1'b0;
        halt_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = '0;
                end
            end
            S_FETCH: state_next = S_EXEC;
            S_EXEC: begin
                state_next = S_FETCH;
                pc_next    = pc + ADDR_W'(1);
                case (opcode)
                    OP_NOP: ;
                    OP_LDI: begin wr_en = 1'b1; wr_val = imm; end
                    OP_MOV: begin wr_en = 1'b1; wr_val = rs_val; end
                    OP_ADD: begin
                        wr_en = 1'b1; flag_en = 1'b1;
                        wr_val = sum_rs[DATA_W-1:0]; alu_c = sum_rs[DATA_W];
                    end
                    OP_SUB: begin
                        wr_en = 1'b1; flag_en = 1'b1;
                        wr_val = diff[DATA_W-1:0]; alu_c = diff[DATA_W];
                    end
                    OP_AND: begin wr_en = 1'b1; flag_en = 1'b1; wr_val = rd_val & rs_val; alu_c = 1'b0; end
                    OP_OR:  begin wr_en = 1'b1; flag_en = 1'b1; wr_val = rd_val | rs_val; alu_c = 1'b0; end
                    OP_XOR: begin wr_en = 1'b1; flag_en = 1'b1; wr_val = rd_val ^ rs_val; alu_c = 1'b0; end
                    OP_SHL: begin
                        wr_en = 1'b1; flag_en = 1'b1;
                        wr_val = {rd_val[DATA_W-2:0], 1'b0}; alu_c = rd_val[DATA_W-1];
                    end
                    OP_SHR: begin
                        wr_en = 1'b1; flag_en = 1'b1;
                        wr_val = {1'b0, rd_val[DATA_W-1:1]}; alu_c = rd_val[0];
                    end
                    OP_ADDI: begin
                        wr_en = 1'b1; flag_en = 1'b1;
                        wr_val = sum_imm[DATA_W-1:0]; alu_c = sum_imm[DATA_W];
                    end
                    OP_JMP: pc_next = jump_target;
                    OP_JZ:  if (flag_z) pc_next = jump_target;
                    OP_JC:  if (flag_c) pc_next = jump_target;
                    OP_OUT: begin
                        if (out_ready) begin
                            out_fire = 1'b1;
                        end else begin
                            state_next = S_EXEC;
                            pc_next    = pc;
                        end
                    end
                    OP_HALT: begin
                        state_next = S_IDLE;
                        pc_next    = pc;
                        halt_set   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign alu_z = (wr_val == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            halted   <= 1'b0;
            out_hold <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == S_FETCH) ir <= mem[pc];
            if (wr_en) regs[rd_idx] <= wr_val;
            if (flag_en) begin
                flag_z <= alu_z;
                flag_c <= alu_c;
            end
            if (out_fire) out_hold <= rd_val;
            if (state == S_IDLE && start) halted <= 1'b0;
            else if (halt_set)            halted <= 1'b1;
        end
    end

    // Program memory is deliberately not reset; loads only land while idle.
    always_ff @(posedge clk) begin
        if (load_en && state == S_IDLE) mem[load_addr] <= load_data;
    end

    assign out_valid = (state == S_EXEC) && (opcode == OP_OUT);
    assign out_data  = out_valid ? rd_val : out_hold;
    assign running   = (state != S_IDLE);
    assign dbg_data  = regs[dbg_sel];

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed scenarios plus random forward-jumping programs,
// all checked against an instruction-level model of the ISA.
`timescale 1ns/1ps
module tb_cpu_core;
    localparam int DATA_W = 8, NUM_REGS = 4, ADDR_W = 4, REG_W = 2, INSTR_W = 16, DEPTH = 16;

    logic               clk = 1'b0, reset = 1'b0, start = 1'b0, load_en = 1'b0, out_ready = 1'b0;
    logic [ADDR_W-1:0]  load_addr = '0;
    logic [INSTR_W-1:0] load_data = '0;
    logic [REG_W-1:0]   dbg_sel = '0;
    logic [DATA_W-1:0]  out_data, dbg_data;
    logic               out_valid, running, halted;
    logic [ADDR_W-1:0]  pc;

    always #5 clk = ~clk;

    cpu_core #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data), .pc(pc), .running(running), .halted(halted)
    );

    int n_cmp = 0, n_err = 0;
    int m_mem [DEPTH];
    int m_regs [NUM_REGS];
    int m_z, m_c, m_steps, cycles;
    int exp_out [$];
    int m_pcs [$];
    int got_out [$];
    int pc_trace [$];
    bit wrap_seen;

    function automatic int enc(int op, int rd, int rs, int imm);
        return op * 4096 + rd * 1024 + rs * 256 + (imm % 256);
    endfunction

    // Instruction-level reference: runs the program in m_mem from pc 0.
    task automatic model_run();
        int p, w, op, rd, rs, imm, a, b, res, t;
        bit done;
        exp_out.delete(); m_pcs.delete();
        m_steps = 0; p = 0; done = 0;
        while (!done && m_steps < 100) begin
            m_pcs.push_back(p);
            w = m_mem[p]; op = w / 4096; rd = (w / 1024) % 4; rs = (w / 256) % 4; imm = w % 256;
            a = m_regs[rd]; b = m_regs[rs]; res = -1;
            m_steps++;
            p = (p + 1) % DEPTH;
            case (op)
                1:  m_regs[rd] = imm;
                2:  m_regs[rd] = b;
                3:  begin t = a + b; m_c = (t > 255); res = t % 256; end
                4:  begin m_c = (a < b); res = (a - b + 256) % 256; end
                5:  begin res = a & b; m_c = 0; end
                6:  begin res = a | b; m_c = 0; end
                7:  begin res = a ^ b; m_c = 0; end
                8:  begin m_c = (a >= 128); res = (a * 2) % 256; end
                9:  begin m_c = a % 2; res = a / 2; end
                10: begin t = a + imm; m_c = (t > 255); res = t % 256; end
                11: p = imm % DEPTH;
                12: if (m_z != 0) p = imm % DEPTH;
                13: if (m_c != 0) p = imm % DEPTH;
                14: exp_out.push_back(a);
                15: done = 1;
                default: ;
            endcase
            if (res >= 0) begin m_regs[rd] = res; m_z = (res == 0); end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; load_en = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 0;
        m_z = 0; m_c = 0;
    endtask

    task automatic fill_halt();
        for (int a = 0; a < DEPTH; a++) m_mem[a] = enc(15, 0, 0, 0);
    endtask

    task automatic load_prog();
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            load_en = 1'b1; load_addr = a[ADDR_W-1:0]; load_data = m_mem[a][INSTR_W-1:0];
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Steps one negedge at a time until halted or budget; mode 0 = ready
    // always high, mode 1 = random ready. Optional load/start injections.
    task automatic run_until_halt(input int mode, input int budget, input int inj_cycle,
                                  input int inj_addr, input int inj_data, input int restart_cycle);
        int prev_pc;
        bit stop;
        got_out.delete(); pc_trace.delete();
        cycles = 0; wrap_seen = 0; stop = 0; prev_pc = int'(pc);
        while (!stop) begin
            out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            load_en   = (cycles == inj_cycle);
            load_addr = inj_addr[ADDR_W-1:0];
            load_data = inj_data[INSTR_W-1:0];
            start     = (cycles == restart_cycle);
            #1;
            pc_trace.push_back(int'(pc));
            if (prev_pc == DEPTH - 1 && pc == 0) wrap_seen = 1;
            prev_pc = int'(pc);
            if (out_valid && out_ready) got_out.push_back(int'(out_data));
            stop = halted || (cycles >= budget);
            if (!stop) begin
                @(negedge clk);
                cycles++;
            end
        end
        load_en = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'd0) begin n_err++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL rst_running: got %0b want 0", running); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %0b want 0", halted); end
        n_cmp++; if (pc !== 4'd0) begin n_err++; $display("FAIL rst_pc: got %0d want 0", pc); end
        for (int r = 0; r < NUM_REGS; r++) begin
            dbg_sel = r[REG_W-1:0]; #1;
            n_cmp++; if (dbg_data !== 8'd0) begin n_err++; $display("FAIL rst_reg%0d: got %0d want 0", r, dbg_data); end
        end
    endtask

    task automatic test_reset_mid_out();
        fill_halt();
        m_mem[0] = enc(1, 0, 0, 77); m_mem[1] = enc(1, 1, 0, 5); m_mem[2] = enc(14, 0, 0, 0);
        load_prog();
        start_pulse();
        out_ready = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_stall_valid: got %0b want 1", out_valid); end
        #1; reset = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'd0) begin n_err++; $display("FAIL mid_rst_data: got %0d want 0", out_data); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL mid_rst_running: got %0b want 0", running); end
        n_cmp++; if (pc !== 4'd0) begin n_err++; $display("FAIL mid_rst_pc: got %0d want 0", pc); end
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 0;
        m_z = 0; m_c = 0;
        for (int r = 0; r < NUM_REGS; r++) begin
            dbg_sel = r[REG_W-1:0]; #1;
            n_cmp++; if (dbg_data !== 8'd0) begin n_err++; $display("FAIL mid_rst_reg%0d: got %0d want 0", r, dbg_data); end
        end
    endtask

    task automatic test_example();
        fill_halt();
        m_mem[0] = enc(1, 0, 0, 200); m_mem[1] = enc(1, 1, 0, 100); m_mem[2] = enc(3, 0, 1, 0);
        m_mem[3] = enc(14, 0, 0, 0);
        load_prog(); model_run(); start_pulse();
        run_until_halt(0, 100, -1, 0, 0, -1);
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL ex_halted: got %0b want 1", halted); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL ex_running: got %0b want 0", running); end
        n_cmp++; if (cycles != 10) begin n_err++; $display("FAIL ex_cycles: got %0d want 10", cycles); end
        n_cmp++; if (got_out.size() != 1 || got_out[0] != 44) begin
            n_err++; $display("FAIL ex_out: got %0d words first %0d want 1 word 44", got_out.size(), (got_out.size() > 0) ? got_out[0] : -1);
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            dbg_sel = r[REG_W-1:0]; #1;
            n_cmp++; if (dbg_data !== m_regs[r][DATA_W-1:0]) begin n_err++; $display("FAIL ex_reg%0d: got %0d want %0d", r, dbg_data, m_regs[r]); end
        end
        // Flags persist across start: C=1, Z=0 steer this one to OUT r1.
        fill_halt();
        m_mem[0] = enc(13, 0, 0, 2); m_mem[2] = enc(12, 0, 0, 1); m_mem[3] = enc(14, 1, 0, 0);
        load_prog(); model_run(); start_pulse();
        run_until_halt(0, 100, -1, 0, 0, -1);
        n_cmp++; if (got_out.size() != 1 || got_out[0] != 100) begin
            n_err++; $display("FAIL ex_flags_out: got %0d words first %0d want 1 word 100", got_out.size(), (got_out.size() > 0) ? got_out[0] : -1);
        end
        n_cmp++; if (got_out.size() != exp_out.size()) begin n_err++; $display("FAIL ex_flags_model: got %0d words want %0d", got_out.size(), exp_out.size()); end
    endtask

    task automatic test_sub_jz();
        fill_halt();
        m_mem[0] = enc(1, 0, 0, 9); m_mem[1] = enc(4, 0, 0, 0); m_mem[2] = enc(12, 0, 0, 6);
        m_mem[6] = enc(13, 0, 0, 3); m_mem[7] = enc(1, 0, 0, 3); m_mem[8] = enc(1, 1, 0, 5);
        m_mem[9] = enc(4, 0, 1, 0); m_mem[10] = enc(13, 0, 0, 12); m_mem[12] = enc(14, 0, 0, 0);
        load_prog(); model_run(); start_pulse();
        run_until_halt(0, 100, -1, 0, 0, -1);
        n_cmp++; if (pc_trace.size() <= 6 || pc_trace[6] != 6) begin n_err++; $display("FAIL jz_pc: got %0d want 6", (pc_trace.size() > 6) ? pc_trace[6] : -1); end
        for (int i = 0; i < m_steps; i++) begin
            n_cmp++;
            if (2 * i >= pc_trace.size() || pc_trace[2 * i] != m_pcs[i]) begin
                n_err++; $display("FAIL jz_pc_trace%0d: got %0d want %0d", i, (2 * i < pc_trace.size()) ? pc_trace[2 * i] : -1, m_pcs[i]);
            end
        end
        n_cmp++; if (got_out.size() != 1 || got_out[0] != 254) begin
            n_err++; $display("FAIL sub_borrow_out: got %0d words first %0d want 1 word 254", got_out.size(), (got_out.size() > 0) ? got_out[0] : -1);
        end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL jz_halted: got %0b want 1", halted); end
    endtask

    task automatic test_stall();
        fill_halt();
        m_mem[0] = enc(1, 2, 0, 8'h5A); m_mem[1] = enc(14, 2, 0, 0); m_mem[2] = enc(10, 2, 0, 1);
        m_mem[3] = enc(14, 2, 0, 0);
        load_prog(); model_run(); start_pulse();
        out_ready = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A || pc !== 4'd1) begin
                n_err++; $display("FAIL stall_hold%0d: got valid %0b data %0d pc %0d want 1 90 1", k, out_valid, out_data, pc);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h5A || pc !== 4'd2) begin
            n_err++; $display("FAIL stall_release: got valid %0b data %0d pc %0d want 0 90 2", out_valid, out_data, pc);
        end
        run_until_halt(0, 100, -1, 0, 0, -1);
        n_cmp++; if (got_out.size() != 1 || got_out[0] != 8'h5B) begin
            n_err++; $display("FAIL stall_resume_out: got %0d words first %0d want 1 word 91", got_out.size(), (got_out.size() > 0) ? got_out[0] : -1);
        end
        dbg_sel = 2'd2; #1;
        n_cmp++; if (dbg_data !== m_regs[2][DATA_W-1:0]) begin n_err++; $display("FAIL stall_reg2: got %0d want %0d", dbg_data, m_regs[2]); end
    endtask

    task automatic test_wrap();
        reset_dut();
        for (int a = 0; a < DEPTH; a++) m_mem[a] = enc(0, 0, 0, 0);
        m_mem[0] = enc(10, 2, 0, 1); m_mem[1] = enc(1, 1, 0, 2); m_mem[2] = enc(2, 3, 2, 0);
        m_mem[3] = enc(7, 3, 1, 0); m_mem[4] = enc(12, 0, 0, 6); m_mem[5] = enc(11, 0, 0, 7);
        m_mem[6] = enc(15, 0, 0, 0);
        load_prog(); model_run(); start_pulse();
        run_until_halt(0, 200, -1, 0, 0, -1);
        n_cmp++; if (wrap_seen !== 1'b1) begin n_err++; $display("FAIL wrap_seen: got %0b want 1", wrap_seen); end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL wrap_halted: got %0b want 1", halted); end
        n_cmp++; if (cycles != 2 * m_steps) begin n_err++; $display("FAIL wrap_cycles: got %0d want %0d", cycles, 2 * m_steps); end
        for (int r = 0; r < NUM_REGS; r++) begin
            dbg_sel = r[REG_W-1:0]; #1;
            n_cmp++; if (dbg_data !== m_regs[r][DATA_W-1:0]) begin n_err++; $display("FAIL wrap_reg%0d: got %0d want %0d", r, dbg_data, m_regs[r]); end
        end
    endtask

    task automatic test_load_start();
        fill_halt();
        m_mem[0] = enc(1, 0, 0, 1); m_mem[1] = enc(10, 0, 0, 2); m_mem[2] = enc(10, 0, 0, 3);
        m_mem[3] = enc(10, 0, 0, 4); m_mem[4] = enc(14, 0, 0, 0); m_mem[5] = enc(14, 3, 0, 0);
        load_prog();
        for (int run = 0; run < 3; run++) begin
            if (run == 2) begin
                @(negedge clk);
                load_en = 1'b1; load_addr = 4'd0; load_data = 16'h1 << 12 | 16'h0C00 | 16'h00C3; start = 1'b1;
                @(negedge clk);
                load_en = 1'b0; start = 1'b0;
                m_mem[0] = enc(1, 3, 0, 8'hC3);
            end else begin
                start_pulse();
            end
            model_run();
            if (run == 0) run_until_halt(0, 100, 3, 1, enc(1, 0, 0, 99), 5);
            else          run_until_halt(0, 100, -1, 0, 0, -1);
            n_cmp++; if (cycles != 2 * m_steps) begin n_err++; $display("FAIL ls_cycles_run%0d: got %0d want %0d", run, cycles, 2 * m_steps); end
            n_cmp++; if (got_out.size() != exp_out.size()) begin n_err++; $display("FAIL ls_outcount_run%0d: got %0d want %0d", run, got_out.size(), exp_out.size()); end
            for (int i = 0; i < exp_out.size() && i < got_out.size(); i++) begin
                n_cmp++; if (got_out[i] != exp_out[i]) begin n_err++; $display("FAIL ls_out_run%0d_%0d: got %0d want %0d", run, i, got_out[i], exp_out[i]); end
            end
        end
        n_cmp++; if (got_out.size() < 2 || got_out[1] != 8'hC3) begin n_err++; $display("FAIL ls_same_cycle: got %0d words, second %0d want 195", got_out.size(), (got_out.size() > 1) ? got_out[1] : -1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            for (int a = 0; a < DEPTH - 1; a++) begin
                int op;
                op = $urandom_range(0, 14);
                if (op >= 11 && op <= 13)
                    m_mem[a] = enc(op, 0, 0, $urandom_range(a + 1, DEPTH - 1) + 16 * $urandom_range(0, 15));
                else
                    m_mem[a] = enc(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
            end
            m_mem[DEPTH - 1] = enc(15, 0, 0, 0);
            load_prog(); model_run(); start_pulse();
            run_until_halt(n % 2, 400, -1, 0, 0, -1);
            n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL rnd%0d_halted: got %0b want 1", n, halted); end
            if (n % 2 == 0) begin
                n_cmp++; if (cycles != 2 * m_steps) begin n_err++; $display("FAIL rnd%0d_cycles: got %0d want %0d", n, cycles, 2 * m_steps); end
            end
            n_cmp++; if (got_out.size() != exp_out.size()) begin n_err++; $display("FAIL rnd%0d_outcount: got %0d want %0d", n, got_out.size(), exp_out.size()); end
            for (int i = 0; i < exp_out.size() && i < got_out.size(); i++) begin
                n_cmp++; if (got_out[i] != exp_out[i]) begin n_err++; $display("FAIL rnd%0d_out%0d: got %0d want %0d", n, i, got_out[i], exp_out[i]); end
            end
            for (int r = 0; r < NUM_REGS; r++) begin
                dbg_sel = r[REG_W-1:0]; #1;
                n_cmp++; if (dbg_data !== m_regs[r][DATA_W-1:0]) begin n_err++; $display("FAIL rnd%0d_reg%0d: got %0d want %0d", n, r, dbg_data, m_regs[r]); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();
        test_reset();
        test_reset_mid_out();
        test_example();
        test_sub_jz();
        test_stall();
        test_wrap();
        test_load_start();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
